// File: rtl/audio_prefetch.sv
// Avalon-MM read master that prefetches 16-bit SDRAM words into a byte FIFO
// feeding the I2S sample path, with playback address and status tracking.
module audio_prefetch #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              loop,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    input  logic [15:0]       m_readdata,
    input  logic              m_waitrequest,
    input  logic              m_readdatavalid,
    input  logic              smp_rd,
    output logic [7:0]        smp_data,
    output logic              smp_valid,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              done,
    output logic [7:0]        underrun_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_STREAM,
        S_AREQ,
        S_ARESP
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] fptr_q, fptr_d;
    logic [ADDR_W-1:0] frem_q, frem_d;
    logic [ADDR_W-1:0] cptr_q, cptr_d;
    logic [ADDR_W-1:0] crem_q, crem_d;
    logic              done_q, done_d;
    logic [7:0]        und_q, und_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [7:0]        mem [DEPTH];

    logic push, pop, flush, active, req_ok;
    logic unused_bits;

    assign unused_bits = base_addr[0] ^ length[0];

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        fptr_d  = fptr_q;
        frem_d  = frem_q;
        cptr_d  = cptr_q;
        crem_d  = crem_q;
        done_d  = done_q;
        und_d   = und_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        active  = (state_q == S_REQ) || (state_q == S_RESP) ||
                  (state_q == S_STREAM);

        if (active && play) begin
            if (smp_rd && cnt_q != '0) begin
                pop    = 1'b1;
                rptr_d = rptr_q + PW'(1);
                if (!done_q) begin
                    cptr_d = cptr_q + ADDR_W'(1);
                    crem_d = crem_q - ADDR_W'(1);
                    if (crem_d == '0) begin
                        if (loop) begin
                            cptr_d = base_q;
                            crem_d = len_q;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
            end else if (smp_rd && !done_q && und_q != 8'hFF) begin
                und_d = und_q + 8'd1;
            end

            if (state_q == S_RESP && m_readdatavalid) begin
                push   = 1'b1;
                wptr_d = wptr_q + PW'(2);
                fptr_d = fptr_q + ADDR_W'(2);
                frem_d = frem_q - ADDR_W'(2);
                if (frem_d == '0 && loop) begin
                    fptr_d = base_q;
                    frem_d = len_q;
                end
            end
        end

        cnt_d  = cnt_q + (push ? CW'(2) : CW'(0)) - (pop ? CW'(1) : CW'(0));
        req_ok = (frem_d != '0) && (cnt_d <= CW'(DEPTH - 2)) && !done_d;

        unique case (state_q)
            S_IDLE: begin
                if (!play) begin
                    done_d = 1'b0;
                end else if (!done_q) begin
                    base_d = {base_addr[ADDR_W-1:1], 1'b0};
                    len_d  = {length[ADDR_W-1:1], 1'b0};
                    fptr_d = base_d;
                    frem_d = len_d;
                    cptr_d = base_d;
                    crem_d = len_d;
                    und_d  = 8'd0;
                    flush  = 1'b1;
                    if (len_d == '0) done_d = 1'b1;
                    else             state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!play) begin
                    flush   = 1'b1;
                    state_d = m_waitrequest ? S_AREQ : S_ARESP;
                end else if (!m_waitrequest) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (!play) begin
                    flush   = 1'b1;
                    state_d = m_readdatavalid ? S_IDLE : S_ARESP;
                end else if (m_readdatavalid) begin
                    state_d = req_ok ? S_REQ : S_STREAM;
                end
            end
            S_STREAM: begin
                if (!play) begin
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end else if (req_ok) begin
                    state_d = S_REQ;
                end
            end
            // Stop with a read in flight: finish the handshake, drop the data.
            S_AREQ:  if (!m_waitrequest) state_d = S_ARESP;
            S_ARESP: if (m_readdatavalid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            fptr_q  <= '0;
            frem_q  <= '0;
            cptr_q  <= '0;
            crem_q  <= '0;
            done_q  <= 1'b0;
            und_q   <= 8'd0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            fptr_q  <= fptr_d;
            frem_q  <= frem_d;
            cptr_q  <= cptr_d;
            crem_q  <= crem_d;
            done_q  <= done_d;
            und_q   <= und_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q]          <= m_readdata[7:0];
            mem[wptr_q + PW'(1)] <= m_readdata[15:8];
        end
    end

    assign m_read       = (state_q == S_REQ) || (state_q == S_AREQ);
    assign m_address    = fptr_q;
    assign smp_valid    = (cnt_q != '0);
    assign smp_data     = smp_valid ? mem[rptr_q] : 8'h00;
    assign cur_addr     = cptr_q;
    assign done         = done_q;
    assign underrun_cnt = und_q;

endmodule

// File: doc/audio_prefetch.md
Name: audio_prefetch

Overview:
- Streams 8-bit audio samples from SDRAM to the I2S transmitter inside the game top level.
- Acts as an Avalon-MM read master that fetches 16-bit words starting at a programmed byte address.
- Splits each word into two bytes and buffers them in a show-ahead FIFO that the I2S side pops once per sample.
- Exports the current playback byte address for the software-visible SDRAM_ADDR register, plus end-of-clip and underrun status.

Parameters:
DEPTH, 16, FIFO capacity in bytes; power of two, minimum 4
ADDR_W, 24, byte-address width for SDRAM and for the clip length

Ports:
clk  in  1  system clock; all logic is in this domain
reset  in  1  asynchronous, active-low reset
play  in  1  level; 1 = play the clip, 0 = stop and flush
base_addr  in  ADDR_W  clip start byte address; bit 0 ignored
length  in  ADDR_W  clip length in bytes; bit 0 ignored (rounded down to even)
loop  in  1  1 = restart at base_addr when the clip ends
m_address  out  ADDR_W  Avalon read byte address; always even
m_read  out  1  Avalon read request
m_readdata  in  16  read word; low byte is the earlier sample
m_waitrequest  in  1  Avalon stall
m_readdatavalid  in  1  read data strobe
smp_rd  in  1  one-cycle pop request from the I2S side
smp_data  out  8  FIFO head byte; 0x00 when the FIFO is empty
smp_valid  out  1  FIFO is non-empty
cur_addr  out  ADDR_W  byte address of the current FIFO head sample
done  out  1  clip finished (non-loop mode)
underrun_cnt  out  8  count of pops attempted while empty during playback; saturates at 255

Behaviour:
- Reset values:
  - outputs: m_read=0, m_address=0, smp_valid=0, smp_data=0, cur_addr=0, done=0, underrun_cnt=0
  - FIFO empty; FSM in IDLE
- FSM states:
  - IDLE: waits for play=1. On entry to playback it latches B=base_addr&~1 and L=length&~1, and clears done, underrun_cnt and the FIFO. fetch_ptr=B, fetch_rem=L, cons_ptr=B, cons_rem=L. If L=0, done=1 and the FSM stays in IDLE until play=0.
  - REQ: asserted when fetch_rem>0 and FIFO free space>=2. Drive m_read=1 with m_address=fetch_ptr. Hold both stable until the cycle in which m_waitrequest=0, then go to RESP.
  - RESP: at most one read is outstanding. On m_readdatavalid, push m_readdata[7:0] then [15:8] (both bytes in one cycle), fetch_ptr+=2, fetch_rem-=2.
    - fetch_rem reaches 0 and loop=1: fetch_ptr=B, fetch_rem=L.
    - Otherwise return to REQ, or to STREAM when there is no space or fetch_rem=0.
  - STREAM: no read pending. Re-enter REQ as soon as its conditions hold.
- Pop:
  - smp_rd with smp_valid=1 removes the head byte; cur_addr=cons_ptr+1, cons_rem-=1.
  - When cons_rem reaches 0: loop=1 sets cons_ptr=B, cons_rem=L. loop=0 sets done=1 (held until play=0) and no further reads are issued.
- Underrun: smp_rd with smp_valid=0, play=1 and done=0 increments underrun_cnt, saturating at 255. FIFO and pointers are unchanged.
- Same-cycle push and pop: both take effect and the count changes by +1. A byte pushed into an empty FIFO is visible on smp_data/smp_valid the following cycle; a pop in the push cycle counts as an underrun.
- Stop (play falls):
  - If m_read is asserted, keep it and m_address until waitrequest=0, then wait for the matching readdatavalid and discard the data.
  - Then flush the FIFO and return to IDLE. smp_valid=0 from the cycle after play falls.
  - cur_addr holds its last value until the next start.
- Address arithmetic: modulo 2^ADDR_W (wraps at the top of the space). Loop reload takes priority over increment.
- base_addr, length and loop are sampled only at start, except that loop is read at each end-of-clip.
- Asserting reset mid-transaction aborts immediately to reset values. The SDRAM controller is reset by the same signal.

Test Plan:
- Fill/stream: base=0x000100, length=6, loop=0, memory words 0x2211, 0x4433, 0x6655, zero-wait slave, pop every 4 cycles -> smp_data sequence 11,22,33,44,55,66; m_address 0x100, 0x102, 0x104; cur_addr 0x100..0x106; done=1 after the 6th pop; no fourth read.
- Backpressure: slave holds m_waitrequest for 5 cycles on the first read -> m_read and m_address=0x100 stable for all 6 cycles; exactly one read accepted.
- FIFO full, DEPTH=16, length=64, no pops -> exactly 8 reads issued, smp_valid=1, m_read stays 0; one pop frees only 1 byte so still no read; a second pop triggers a read at 0x110.
- Loop: base=0x200, length=4, loop=1, 10 pops -> bytes repeat with period 4; cur_addr wraps 0x203 -> 0x200; done stays 0.
- Underrun/odd length: length=5 (treated as 4), slave delays readdatavalid by 20 cycles, pop at cycle 2 and 3 -> underrun_cnt=2, smp_data=0x00; after 4 pops done=1; further pops do not increment.
- Stop mid-read: play falls while m_read=1 and waitrequest=1 -> m_read held until accept; data discarded; FIFO empty; FSM in IDLE. A new start with base=0x300 fetches from 0x300.
